decode_stage: RTL and testbench

- Pipeline stage directly downstream of instruction fetch; consumes fetched PC, IR and valid each cycle.
- Splits the IR into fields and reads the register file.
- Owns a per-register busy scoreboard; generates the dependency and branch stall signals that fetch obeys.
- Issues decoded operands to the execute stage; receives writeback updates from the last stage.

---
 rtl/decode_stage.sv | 150 +++++++++++++++
 tb/tb_decode_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: splits the fetched IR, reads the register file, tracks per-register busy bits and issues to execute.
// Optional macro DECODE_WB_BYPASS_EN: a same-cycle writeback clears the hazard and forwards I_WB_Data as the operand.
module decode_stage #(
    parameter int PC_WIDTH  = 16,
    parameter int IR_WIDTH  = 32,
    parameter int REG_WIDTH = 16,
    parameter int NUM_REGS  = 16
) (
    input  logic                 I_CLOCK,
    input  logic                 I_LOCK,
    input  logic [PC_WIDTH-1:0]  I_PC,
    input  logic [IR_WIDTH-1:0]  I_IR,
    input  logic                 I_FE_Valid,
    input  logic                 I_BranchAddrSelect,
    input  logic                 I_GPUStallSignal,
    input  logic                 I_WB_Valid,
    input  logic                 I_WB_RegWrEn,
    input  logic [3:0]           I_WB_DestIdx,
    input  logic [REG_WIDTH-1:0] I_WB_Data,
    output logic                 O_LOCK,
    output logic [PC_WIDTH-1:0]  O_PC,
    output logic [7:0]           O_Opcode,
    output logic [3:0]           O_DestIdx,
    output logic [REG_WIDTH-1:0] O_Src1Value,
    output logic [REG_WIDTH-1:0] O_Src2Value,
    output logic [REG_WIDTH-1:0] O_Imm,
    output logic                 O_DE_Valid,
    output logic                 O_DepStallSignal,
    output logic                 O_BranchStallSignal
);

    logic [REG_WIDTH-1:0] rf_reg [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_reg;
    logic                 branch_pending_reg;

    logic [3:0] cls, rd_idx, rs1_idx, rs2_idx;
    logic       reads_rs1, reads_rs2, writes_rd, is_branch;
    logic       wb_en, dep_hazard, issue;
    logic [NUM_REGS-1:0]  wb_hit, busy_eff, busy_next;
    logic [REG_WIDTH-1:0] src1_val, src2_val;

    assign cls     = I_IR[31:28];
    assign rd_idx  = I_IR[23:20];
    assign rs1_idx = I_IR[19:16];
    assign rs2_idx = I_IR[11:8];

    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        writes_rd = 1'b0;
        is_branch = 1'b0;
        case (cls)
            4'd0: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
            4'd1: begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
            4'd2: begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
            4'd3: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
            4'd4: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; is_branch = 1'b1; end
            4'd5: begin reads_rs1 = 1'b1; writes_rd = 1'b1; is_branch = 1'b1; end
            default: ;
        endcase
    end

    assign wb_en = I_WB_Valid & I_WB_RegWrEn;

    // Per-register scoreboard: an issue setting a bit beats a writeback clearing it on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            assign wb_hit[gi] = wb_en && (I_WB_DestIdx == 4'(gi));
`ifdef DECODE_WB_BYPASS_EN
            assign busy_eff[gi] = busy_reg[gi] & ~wb_hit[gi];
`else
            assign busy_eff[gi] = busy_reg[gi];
`endif
            assign busy_next[gi] = (issue && writes_rd && (rd_idx == 4'(gi))) ? 1'b1 :
                                   (wb_hit[gi] ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

`ifdef DECODE_WB_BYPASS_EN
    assign src1_val = wb_hit[rs1_idx] ? I_WB_Data : rf_reg[rs1_idx];
    assign src2_val = wb_hit[rs2_idx] ? I_WB_Data : rf_reg[rs2_idx];
`else
    assign src1_val = rf_reg[rs1_idx];
    assign src2_val = rf_reg[rs2_idx];
`endif

    // Wrong-path instructions behind a pending branch are dropped, so they never raise a hazard.
    assign dep_hazard = I_FE_Valid & ~branch_pending_reg &
                        ((reads_rs1 & busy_eff[rs1_idx]) |
                         (reads_rs2 & busy_eff[rs2_idx]) |
                         (writes_rd & busy_eff[rd_idx]));

    assign O_DepStallSignal    = dep_hazard | I_GPUStallSignal;
    assign O_BranchStallSignal = branch_pending_reg | (I_FE_Valid & is_branch);
    assign issue               = I_FE_Valid & ~branch_pending_reg & ~O_DepStallSignal;

    always_ff @(negedge I_CLOCK) begin
        O_LOCK <= I_LOCK;
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wb_en) begin
            rf_reg[I_WB_DestIdx] <= I_WB_Data;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            busy_reg           <= '0;
            branch_pending_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            if (issue && is_branch) begin
                branch_pending_reg <= 1'b1;
            end else if (I_BranchAddrSelect) begin
                branch_pending_reg <= 1'b0;
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            O_PC        <= '0;
            O_Opcode    <= 8'hFF;
            O_DestIdx   <= '0;
            O_Src1Value <= '0;
            O_Src2Value <= '0;
            O_Imm       <= '0;
            O_DE_Valid  <= 1'b0;
        end else if (!I_GPUStallSignal) begin
            if (issue) begin
                O_PC        <= I_PC;
                O_Opcode    <= I_IR[31:24];
                O_DestIdx   <= rd_idx;
                O_Src1Value <= src1_val;
                O_Src2Value <= src2_val;
                O_Imm       <= REG_WIDTH'(I_IR[15:0]);
                O_DE_Valid  <= 1'b1;
            end else begin
                O_DE_Valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected issues are queued as stimulus is driven and checked at each negedge.
module tb_decode_stage;

    logic        I_CLOCK = 1'b0;
    logic        I_LOCK = 1'b0;
    logic [15:0] I_PC = '0;
    logic [31:0] I_IR = '0;
    logic        I_FE_Valid = 1'b0;
    logic        I_BranchAddrSelect = 1'b0;
    logic        I_GPUStallSignal = 1'b0;
    logic        I_WB_Valid = 1'b0;
    logic        I_WB_RegWrEn = 1'b0;
    logic [3:0]  I_WB_DestIdx = '0;
    logic [15:0] I_WB_Data = '0;
    logic        O_LOCK;
    logic [15:0] O_PC;
    logic [7:0]  O_Opcode;
    logic [3:0]  O_DestIdx;
    logic [15:0] O_Src1Value;
    logic [15:0] O_Src2Value;
    logic [15:0] O_Imm;
    logic        O_DE_Valid;
    logic        O_DepStallSignal;
    logic        O_BranchStallSignal;

    decode_stage dut (
        .I_CLOCK(I_CLOCK), .I_LOCK(I_LOCK), .I_PC(I_PC), .I_IR(I_IR),
        .I_FE_Valid(I_FE_Valid), .I_BranchAddrSelect(I_BranchAddrSelect),
        .I_GPUStallSignal(I_GPUStallSignal), .I_WB_Valid(I_WB_Valid),
        .I_WB_RegWrEn(I_WB_RegWrEn), .I_WB_DestIdx(I_WB_DestIdx), .I_WB_Data(I_WB_Data),
        .O_LOCK(O_LOCK), .O_PC(O_PC), .O_Opcode(O_Opcode), .O_DestIdx(O_DestIdx),
        .O_Src1Value(O_Src1Value), .O_Src2Value(O_Src2Value), .O_Imm(O_Imm),
        .O_DE_Valid(O_DE_Valid), .O_DepStallSignal(O_DepStallSignal),
        .O_BranchStallSignal(O_BranchStallSignal)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  op;
        logic [3:0]  dest;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] imm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Inputs change at posedge+1; the DUT latches on the following negedge.
    task automatic tick();
        @(negedge I_CLOCK);
        @(posedge I_CLOCK);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [7:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic void push_exp(input logic [15:0] pc, input logic [7:0] op, input logic [3:0] dest,
                                     input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] imm);
        exp_t e;
        e.pc = pc; e.op = op; e.dest = dest; e.s1 = s1; e.s2 = s2; e.imm = imm;
        q.push_back(e);
    endfunction

    task automatic fetch(input logic [15:0] pc, input logic [31:0] ir);
        I_PC = pc;
        I_IR = ir;
        I_FE_Valid = 1'b1;
    endtask

    task automatic writeback(input logic en, input logic [3:0] idx, input logic [15:0] data);
        I_WB_Valid = en;
        I_WB_RegWrEn = en;
        I_WB_DestIdx = idx;
        I_WB_Data = data;
    endtask

    // Every unfrozen negedge either retires one queued expectation or must show no issue.
    always @(negedge I_CLOCK) begin : monitor
        logic frz;
        exp_t e;
        frz = I_GPUStallSignal;
        #1;
        if (mon_en && !frz) begin
            checks++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (O_DE_Valid !== 1'b1 || O_PC !== e.pc || O_Opcode !== e.op || O_DestIdx !== e.dest ||
                    O_Src1Value !== e.s1 || O_Src2Value !== e.s2 || O_Imm !== e.imm) begin
                    errors++;
                    $display("FAIL issue: got v=%b pc=%h op=%h rd=%h s1=%h s2=%h imm=%h, expected v=1 pc=%h op=%h rd=%h s1=%h s2=%h imm=%h",
                             O_DE_Valid, O_PC, O_Opcode, O_DestIdx, O_Src1Value, O_Src2Value, O_Imm,
                             e.pc, e.op, e.dest, e.s1, e.s2, e.imm);
                end else begin
                    $display("issue pc=%h op=%h rd=%h s1=%h s2=%h imm=%h ok", O_PC, O_Opcode, O_DestIdx,
                             O_Src1Value, O_Src2Value, O_Imm);
                end
            end else if (O_DE_Valid !== 1'b0) begin
                errors++;
                $display("FAIL no_issue: O_DE_Valid=%b pc=%h, expected 0", O_DE_Valid, O_PC);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            I_LOCK = 1'b0;
            I_PC = 16'($urandom);
            I_IR = $urandom;
            I_FE_Valid = 1'($urandom_range(0, 1));
            I_BranchAddrSelect = 1'($urandom_range(0, 1));
            I_GPUStallSignal = 1'($urandom_range(0, 1));
            writeback(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
            tick();
        end
        checks++;
        if (O_Opcode !== 8'hFF || O_DE_Valid !== 1'b0 || O_PC !== 16'h0 || O_Imm !== 16'h0 ||
            O_Src1Value !== 16'h0 || O_DestIdx !== 4'h0 || O_LOCK !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: op=%h v=%b pc=%h imm=%h s1=%h rd=%h lock=%b, expected FF 0 0 0 0 0 0",
                     O_Opcode, O_DE_Valid, O_PC, O_Imm, O_Src1Value, O_DestIdx, O_LOCK);
        end
        I_FE_Valid = 1'b0; I_BranchAddrSelect = 1'b0; I_GPUStallSignal = 1'b0;
        writeback(1'b0, 4'h0, 16'h0);
        I_LOCK = 1'b1;
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0 || O_BranchStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL reset_stalls: dep=%b br=%b, expected 0 0", O_DepStallSignal, O_BranchStallSignal);
        end
        tick();
        checks++;
        if (O_LOCK !== 1'b1 || O_DE_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: lock=%b v=%b, expected 1 0", O_LOCK, O_DE_Valid);
        end
        $display("reset done");
        mon_en = 1'b1;
    endtask

    task automatic test_independent();
        fetch(16'h0100, mk_ir(8'h01, 4'd1, 4'd2, 16'h035A));
        push_exp(16'h0100, 8'h01, 4'd1, 16'h0, 16'h0, 16'h035A);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0 || O_BranchStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL indep_stall0: dep=%b br=%b, expected 0 0", O_DepStallSignal, O_BranchStallSignal);
        end
        tick();
        fetch(16'h0104, mk_ir(8'h12, 4'd4, 4'd5, 16'hBEEF));
        push_exp(16'h0104, 8'h12, 4'd4, 16'h0, 16'h0, 16'hBEEF);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL indep_stall1: dep=%b, expected 0", O_DepStallSignal);
        end
        tick();
        I_FE_Valid = 1'b0;
        writeback(1'b1, 4'd1, 16'h0000);
        tick();
        writeback(1'b1, 4'd4, 16'h0044);
        tick();
        writeback(1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_raw_hazard();
        fetch(16'h0200, mk_ir(8'h20, 4'd1, 4'd6, 16'h0008));
        push_exp(16'h0200, 8'h20, 4'd1, 16'h0, 16'h0, 16'h0008);
        tick();
        fetch(16'h0204, mk_ir(8'h03, 4'd2, 4'd1, 16'h0000));
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (O_DepStallSignal !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall_%0d: dep=%b, expected 1", i, O_DepStallSignal);
            end
            tick();
        end
        writeback(1'b1, 4'd1, 16'h00AB);
`ifdef DECODE_WB_BYPASS_EN
        push_exp(16'h0204, 8'h03, 4'd2, 16'h00AB, 16'h0, 16'h0000);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL raw_wb_cycle: dep=%b, expected 0 (bypass)", O_DepStallSignal);
        end
        tick();
        writeback(1'b0, 4'd0, 16'h0);
`else
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b1) begin
            errors++;
            $display("FAIL raw_wb_cycle: dep=%b, expected 1", O_DepStallSignal);
        end
        tick();
        writeback(1'b0, 4'd0, 16'h0);
        push_exp(16'h0204, 8'h03, 4'd2, 16'h00AB, 16'h0, 16'h0000);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL raw_after_wb: dep=%b, expected 0", O_DepStallSignal);
        end
        tick();
`endif
        I_FE_Valid = 1'b0;
        writeback(1'b1, 4'd2, 16'h0022);
        tick();
        writeback(1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_branch();
        fetch(16'h0010, mk_ir(8'h40, 4'd0, 4'd3, 16'h0400));
        push_exp(16'h0010, 8'h40, 4'd0, 16'h0, 16'h0044, 16'h0400);
        #1;
        checks++;
        if (O_BranchStallSignal !== 1'b1 || O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL br_issue: br=%b dep=%b, expected 1 0", O_BranchStallSignal, O_DepStallSignal);
        end
        tick();
        fetch(16'h0014, mk_ir(8'h01, 4'd5, 4'd1, 16'h0200));
        #1;
        checks++;
        if (O_BranchStallSignal !== 1'b1 || O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL br_wrong0: br=%b dep=%b, expected 1 0", O_BranchStallSignal, O_DepStallSignal);
        end
        tick();
        fetch(16'h0018, mk_ir(8'h20, 4'd6, 4'd5, 16'h0000));
        #1;
        checks++;
        if (O_BranchStallSignal !== 1'b1 || O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL br_wrong1: br=%b dep=%b, expected 1 0", O_BranchStallSignal, O_DepStallSignal);
        end
        tick();
        I_FE_Valid = 1'b0;
        I_BranchAddrSelect = 1'b1;
        #1;
        checks++;
        if (O_BranchStallSignal !== 1'b1) begin
            errors++;
            $display("FAIL br_pulse: br=%b, expected 1", O_BranchStallSignal);
        end
        tick();
        I_BranchAddrSelect = 1'b0;
        fetch(16'h0020, mk_ir(8'h05, 4'd7, 4'd5, 16'h0634));
        push_exp(16'h0020, 8'h05, 4'd7, 16'h0, 16'h0, 16'h0634);
        #1;
        checks++;
        if (O_BranchStallSignal !== 1'b0 || O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL br_resume: br=%b dep=%b, expected 0 0", O_BranchStallSignal, O_DepStallSignal);
        end
        tick();
    endtask

    task automatic test_gpu_freeze();
        fetch(16'h0030, mk_ir(8'h18, 4'd8, 4'd9, 16'h0F0F));
        I_GPUStallSignal = 1'b1;
        writeback(1'b1, 4'd7, 16'h0777);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (O_DepStallSignal !== 1'b1) begin
                errors++;
                $display("FAIL gpu_dep_%0d: dep=%b, expected 1", i, O_DepStallSignal);
            end
            tick();
            writeback(1'b0, 4'd0, 16'h0);
            checks++;
            if (O_DE_Valid !== 1'b1 || O_PC !== 16'h0020 || O_Opcode !== 8'h05 || O_Imm !== 16'h0634) begin
                errors++;
                $display("FAIL gpu_frozen_%0d: v=%b pc=%h op=%h imm=%h, expected 1 0020 05 0634",
                         i, O_DE_Valid, O_PC, O_Opcode, O_Imm);
            end
        end
        I_GPUStallSignal = 1'b0;
        push_exp(16'h0030, 8'h18, 4'd8, 16'h0, 16'h0, 16'h0F0F);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL gpu_release: dep=%b, expected 0", O_DepStallSignal);
        end
        tick();
        fetch(16'h0034, mk_ir(8'h0A, 4'd10, 4'd7, 16'h0700));
        push_exp(16'h0034, 8'h0A, 4'd10, 16'h0777, 16'h0777, 16'h0700);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL gpu_busy7_cleared: dep=%b, expected 0", O_DepStallSignal);
        end
        tick();
        I_FE_Valid = 1'b0;
        tick();
    endtask

    task automatic test_waw_reset();
        fetch(16'h0040, mk_ir(8'h23, 4'd3, 4'd4, 16'h0001));
        push_exp(16'h0040, 8'h23, 4'd3, 16'h0044, 16'h0, 16'h0001);
        tick();
        fetch(16'h0044, mk_ir(8'h00, 4'd3, 4'd11, 16'h0C00));
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (O_DepStallSignal !== 1'b1) begin
                errors++;
                $display("FAIL waw_stall_%0d: dep=%b, expected 1", i, O_DepStallSignal);
            end
            tick();
        end
        I_LOCK = 1'b0;
        tick();
        checks++;
        if (O_Opcode !== 8'hFF || O_DE_Valid !== 1'b0 || O_LOCK !== 1'b0) begin
            errors++;
            $display("FAIL waw_reset: op=%h v=%b lock=%b, expected FF 0 0", O_Opcode, O_DE_Valid, O_LOCK);
        end
        I_LOCK = 1'b1;
        push_exp(16'h0044, 8'h00, 4'd3, 16'h0, 16'h0, 16'h0C00);
        #1;
        checks++;
        if (O_DepStallSignal !== 1'b0) begin
            errors++;
            $display("FAIL waw_after_reset: dep=%b, expected 0", O_DepStallSignal);
        end
        tick();
        I_FE_Valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_hazard();
        test_branch();
        test_gpu_freeze();
        test_waw_reset();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
